// File: rtl/event_history_mem.sv
// event_history_mem: per-LP event-history RAM shared by all cores through a round-robin arbiter.
// Define HIST_STATS_EN to add granted read/write and arbitration-conflict counters.
module event_history_mem #(
   parameter int NIDB = 3,
   parameter int NCB  = 2,
   parameter int HDW  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [(1<<NCB)-1:0]        hist_rq,
   input  logic [(1<<NCB)-1:0]        hist_wr_en,
   input  logic [(1<<NCB)*8-1:0]      hist_addr,
   input  logic [(1<<NCB)*HDW-1:0]    hist_data_wr,
   input  logic [(1<<NCB)*NIDB-1:0]   hist_lp,
   output logic [(1<<NCB)-1:0]        hist_access_grant,
   output logic [HDW-1:0]             hist_data_rd,
   output logic [(1<<NCB)*4-1:0]      hist_size,
   output logic                       init_done
`ifdef HIST_STATS_EN
  ,output logic [31:0]                stat_rd_cnt,
   output logic [31:0]                stat_wr_cnt,
   output logic [31:0]                stat_conflict_cnt
`endif
);

   localparam int NUM_CORE = 1 << NCB;
   localparam int NUM_LP   = 1 << NIDB;
   localparam int AW       = NIDB + 4;
   localparam int DEPTH    = 1 << AW;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t            state, state_nxt;
   logic [AW-1:0]     clr_cnt;
   logic [NCB-1:0]    rr_ptr;
   logic [HDW-1:0]    mem [DEPTH];
   logic [3:0]        size_tbl [NUM_LP];

   logic              req_win;
   logic [NCB-1:0]    gnt_idx;
   logic [NCB-1:0]    cand;
   logic              gnt_wr;
   logic [7:0]        gnt_addr;
   logic [HDW-1:0]    gnt_data;
   logic              access, do_wr, do_rd;
   logic [AW-1:0]     ram_idx;
   logic [NIDB-1:0]   gnt_lp;
   logic [3:0]        gnt_slot;
   logic [3:0]        slot_len;
   logic              unused_addr_hi;

   // Round-robin search starting at rr_ptr; the first requester found wins.
   always_comb begin
      req_win = 1'b0;
      gnt_idx = rr_ptr;
      cand    = rr_ptr;
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
         cand = rr_ptr + NCB'(i);
         if (!req_win && hist_rq[cand]) begin
            req_win = 1'b1;
            gnt_idx = cand;
         end
      end
   end

   always_comb begin
      gnt_wr   = 1'b0;
      gnt_addr = '0;
      gnt_data = '0;
      for (int unsigned i = 0; i < NUM_CORE; i++) begin
         if (NCB'(i) == gnt_idx) begin
            gnt_wr   = hist_wr_en[i];
            gnt_addr = hist_addr[8*i +: 8];
            gnt_data = hist_data_wr[HDW*i +: HDW];
         end
      end
   end

   always_comb begin
      access         = (state == ST_RUN) && req_win;
      do_wr          = access && gnt_wr;
      do_rd          = access && !gnt_wr;
      ram_idx        = gnt_addr[AW-1:0];
      gnt_lp         = gnt_addr[AW-1:4];
      gnt_slot       = gnt_addr[3:0];
      slot_len       = (gnt_slot == 4'hF) ? 4'hF : gnt_slot + 4'd1;
      unused_addr_hi = ^gnt_addr[7:AW];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_INIT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (state == ST_INIT && clr_cnt == AW'(DEPTH - 1)) state_nxt = ST_RUN;
   end

   always_comb begin
      hist_access_grant = '0;
      if (access) hist_access_grant[gnt_idx] = 1'b1;
   end

   // Storage has no reset; INIT sweeps zeros through it before any grant.
   always_ff @(posedge clk) begin
      if (state == ST_INIT) mem[clr_cnt] <= '0;
      else if (do_wr)       mem[ram_idx] <= gnt_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_cnt      <= '0;
         init_done    <= 1'b0;
         rr_ptr       <= '0;
         hist_data_rd <= '0;
         for (int unsigned l = 0; l < NUM_LP; l++) size_tbl[l] <= '0;
      end else begin
         if (state == ST_INIT) begin
            clr_cnt <= clr_cnt + AW'(1);
            if (clr_cnt == AW'(DEPTH - 1)) init_done <= 1'b1;
         end
         if (access) rr_ptr <= gnt_idx + NCB'(1);
         if (do_rd)  hist_data_rd <= mem[ram_idx];
         if (do_wr && slot_len > size_tbl[gnt_lp]) size_tbl[gnt_lp] <= slot_len;
      end
   end

   always_comb begin
      hist_size = '0;
      for (int unsigned c = 0; c < NUM_CORE; c++)
         hist_size[4*c +: 4] = size_tbl[hist_lp[NIDB*c +: NIDB]];
   end

`ifdef HIST_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_rd_cnt       <= '0;
         stat_wr_cnt       <= '0;
         stat_conflict_cnt <= '0;
      end else begin
         if (do_rd) stat_rd_cnt <= stat_rd_cnt + 32'd1;
         if (do_wr) stat_wr_cnt <= stat_wr_cnt + 32'd1;
         if (state == ST_RUN && |(hist_rq & ~hist_access_grant))
            stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_event_history_mem.sv
// Scoreboard bench for event_history_mem: reference model predicts grants, sizes and read data.
// Define HIST_STATS_EN to also check the statistics counters.
module tb_event_history_mem;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [3:0]    hist_rq = '0;
   logic [3:0]    hist_wr_en = '0;
   logic [31:0]   hist_addr = '0;
   logic [127:0]  hist_data_wr = '0;
   logic [11:0]   hist_lp = '0;
   logic [3:0]    hist_access_grant;
   logic [31:0]   hist_data_rd;
   logic [15:0]   hist_size;
   logic          init_done;
`ifdef HIST_STATS_EN
   logic [31:0]   stat_rd_cnt, stat_wr_cnt, stat_conflict_cnt;
`endif

   event_history_mem #(.NIDB(3), .NCB(2), .HDW(32)) dut (
      .clk(clk), .rst_n(rst_n), .hist_rq(hist_rq), .hist_wr_en(hist_wr_en),
      .hist_addr(hist_addr), .hist_data_wr(hist_data_wr), .hist_lp(hist_lp),
      .hist_access_grant(hist_access_grant), .hist_data_rd(hist_data_rd),
      .hist_size(hist_size), .init_done(init_done)
`ifdef HIST_STATS_EN
     ,.stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt),
      .stat_conflict_cnt(stat_conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference model state
   logic [31:0]   m_mem [128];
   int            m_size [8];
   int            m_ptr;
   bit            m_run;
   int unsigned   m_rd, m_wr, m_conf;
   logic [31:0]   exp_q [$];
   bit            rd_pend = 1'b0;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 128; i++) m_mem[i] = '0;
      for (int i = 0; i < 8; i++) m_size[i] = 0;
      m_ptr = 0; m_run = 1'b0; m_rd = 0; m_wr = 0; m_conf = 0;
   endfunction

   // Called at the negedge: inputs are stable, outputs reflect this cycle.
   task automatic model_step();
      int g;
      int lp, slot, len, idx;
      logic [7:0] a;
      logic [3:0] exp_gnt;
      check("init_done", {31'd0, init_done}, {31'd0, m_run});
      for (int c = 0; c < 4; c++)
         check($sformatf("hist_size[%0d]", c), {28'd0, hist_size[4*c +: 4]},
               32'(m_size[hist_lp[3*c +: 3]]));
      g = -1;
      if (m_run)
         for (int k = 0; k < 4; k++)
            if (g < 0 && hist_rq[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      exp_gnt = (g >= 0) ? 4'(1 << g) : 4'd0;
      check("grant", {28'd0, hist_access_grant}, {28'd0, exp_gnt});
      if (m_run && (hist_rq & ~exp_gnt) != 4'd0) m_conf++;
      if (g >= 0) begin
         m_ptr = (g + 1) % 4;
         a    = hist_addr[8*g +: 8];
         idx  = int'(a[6:0]);
         if (hist_wr_en[g]) begin
            m_mem[idx] = hist_data_wr[32*g +: 32];
            lp   = int'(a[6:4]);
            slot = int'(a[3:0]);
            len  = (slot + 1 > 15) ? 15 : slot + 1;
            if (len > m_size[lp]) m_size[lp] = len;
            m_wr++;
         end else begin
            exp_q.push_back(m_mem[idx]);
            m_rd++;
         end
      end
   endtask

   // Monitor: read data is presented the cycle after a DUT read grant.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         rd_pend = 1'b0;
      end else begin
         if (rd_pend) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL rd_data: got %h expected nothing (scoreboard empty)", hist_data_rd);
            end else begin
               check("rd_data", hist_data_rd, exp_q.pop_front());
            end
         end
         rd_pend = |(hist_access_grant & ~hist_wr_en);
      end
   end

   task automatic cycle();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hist_rq = '0; hist_wr_en = '0;
   endtask

   task automatic drive(int c, bit wr, logic [7:0] a, logic [31:0] d);
      hist_rq[c] = 1'b1;
      hist_wr_en[c] = wr;
      hist_addr[8*c +: 8] = a;
      hist_data_wr[32*c +: 32] = d;
   endtask

   // Reset pulse of one cycle; requests are held high to show grants stay off.
   task automatic do_reset();
      rst_n = 1'b0;
      hist_rq = '1; hist_wr_en = '0;
      @(negedge clk);
      check("rst_grant", {28'd0, hist_access_grant}, 32'd0);
      check("rst_data_rd", hist_data_rd, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_size", {16'd0, hist_size}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic init_wait(int n, bit complete);
      for (int k = 0; k < n; k++) begin
         hist_lp = 12'($urandom);
         @(negedge clk);
         check("init_grant", {28'd0, hist_access_grant}, 32'd0);
         check("init_done_low", {31'd0, init_done}, 32'd0);
         check("init_data_rd", hist_data_rd, 32'd0);
         if (k == 0) check("init_size", {16'd0, hist_size}, 32'd0);
         @(posedge clk);
         #1;
      end
      if (complete) m_run = 1'b1;
   endtask

`ifdef HIST_STATS_EN
   task automatic check_stats();
      check("stat_rd_cnt", stat_rd_cnt, m_rd);
      check("stat_wr_cnt", stat_wr_cnt, m_wr);
      check("stat_conflict_cnt", stat_conflict_cnt, m_conf);
   endtask
`endif

   task automatic random_run(int n);
      for (int i = 0; i < n; i++) begin
         hist_rq      = 4'($urandom);
         hist_wr_en   = 4'($urandom);
         hist_addr    = $urandom;
         hist_data_wr = {$urandom, $urandom, $urandom, $urandom};
         hist_lp      = 12'($urandom);
         cycle();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      #1;
      do_reset();
      init_wait(128, 1'b1);

      // All four cores read continuously: grant order 0,1,2,3,0
      for (int c = 0; c < 4; c++) drive(c, 1'b0, 8'(c * 17), 32'd0);
      repeat (5) cycle();
      idle();

      // Sweep every RAM word: all cleared during INIT
      for (int i = 0; i < 128; i++) begin
         idle();
         drive(0, 1'b0, 8'(i), 32'd0);
         cycle();
      end

      // Write then read-after-write through core 1, LP 3 slot 5
      idle();
      hist_lp = {3'd3, 3'd3, 3'd3, 3'd3};
      drive(1, 1'b1, 8'h35, 32'hDEADBEEF);
      cycle();
      idle();
      drive(1, 1'b0, 8'h35, 32'h0);
      cycle();
      idle();
      cycle();
      check("size_lp3", {28'd0, hist_size[7:4]}, 32'd6);

      // LP 2: slots 3, 1, 15 then reads
      hist_lp = {3'd2, 3'd2, 3'd2, 3'd2};
      drive(2, 1'b1, 8'h23, 32'h1111_0003); cycle(); idle();
      drive(2, 1'b1, 8'h21, 32'h1111_0001); cycle(); idle();
      drive(2, 1'b1, 8'h2F, 32'h1111_000F); cycle(); idle();
      drive(3, 1'b0, 8'h2F, 32'h0); cycle(); idle();
      drive(3, 1'b0, 8'h23, 32'h0); cycle(); idle();
      cycle();
      check("size_lp2_sat", {28'd0, hist_size[15:12]}, 32'd15);

      // Simultaneous reads from cores 0 and 2, then a core 0 write
      drive(0, 1'b0, 8'h10, 32'h0);
      drive(2, 1'b0, 8'h20, 32'h0);
      cycle();
      if (hist_access_grant[0]) hist_rq[0] = 1'b0;
      if (hist_access_grant[2]) hist_rq[2] = 1'b0;
      cycle();
      idle();
      drive(0, 1'b1, 8'h44, 32'hCAFE_F00D);
      cycle();
      idle();
      cycle();

      random_run(1500);
      idle();
      cycle();
`ifdef HIST_STATS_EN
      check_stats();
`endif

      // Reset in RUN, then again at INIT cycle 50
      do_reset();
      init_wait(50, 1'b0);
      do_reset();
      init_wait(128, 1'b1);
      for (int i = 0; i < 8; i++) begin
         idle();
         drive(i % 4, 1'b0, 8'(i * 9), 32'h0);
         cycle();
      end
      random_run(300);
      idle();
      cycle();
      cycle();
`ifdef HIST_STATS_EN
      check_stats();
`endif
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
